// File: rtl/rf_wport_arb_pkg.sv
// Shared defaults and the buffered-result entry type for the register-file
// write-port arbiter.
package rf_wport_arb_pkg;

  localparam int FIFO_DEPTH_DEF = 2;
  localparam int STARVE_MAX_DEF = 3;

  typedef struct packed {
    logic [4:0]  dest;
    logic [31:0] data;
  } wport_entry_t;

endpackage

// File: rtl/rf_wport_arb_if.sv
// Bundle of WB-stage, multi-cycle-unit, register-file and ID-lookup signals.
// Handshakes: an mdu result transfers on a cycle where mdu_valid & mdu_ready
// are both high at the rising edge; WB holds its instruction while wb_stall is high.
interface rf_wport_arb_if;
  logic        wb_we;
  logic [4:0]  wb_waddr;
  logic [31:0] wb_wdata;
  logic        wb_stall;
  logic        mdu_valid;
  logic [4:0]  mdu_dest;
  logic [31:0] mdu_data;
  logic        mdu_ready;
  logic        flush;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [4:0]  raddr1;
  logic [4:0]  raddr2;
  logic        pend_hit1;
  logic        pend_hit2;
  logic [7:0]  dbg_count;
  logic [7:0]  dbg_starve;

  modport master (
    output wb_we, wb_waddr, wb_wdata, mdu_valid, mdu_dest, mdu_data, flush,
           raddr1, raddr2,
    input  wb_stall, mdu_ready, rf_we, rf_waddr, rf_wdata, pend_hit1, pend_hit2,
           dbg_count, dbg_starve
  );

  modport slave (
    input  wb_we, wb_waddr, wb_wdata, mdu_valid, mdu_dest, mdu_data, flush,
           raddr1, raddr2,
    output wb_stall, mdu_ready, rf_we, rf_waddr, rf_wdata, pend_hit1, pend_hit2,
           dbg_count, dbg_starve
  );
endinterface

// File: rtl/wport_fifo.sv
// In-order buffer of multi-cycle-unit results with a per-entry dest/valid view
// so the arbiter can flag pending destinations to the ID stage.
module wport_fifo
  import rf_wport_arb_pkg::*;
#(
  parameter  int DEPTH = FIFO_DEPTH_DEF,
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  wport_entry_t          push_entry,
  input  logic                  pop,
  input  logic                  flush,
  output logic [CW-1:0]         count,
  output wport_entry_t          head,
  output logic [DEPTH-1:0][4:0] ent_dest,
  output logic [DEPTH-1:0]      ent_valid
);

  wport_entry_t  mem_q [DEPTH];
  wport_entry_t  mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_en, pop_en;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) return '0;
    return p + 1'b1;
  endfunction

  always_comb begin
    push_en  = push & !flush & (count_q < CW'(DEPTH));
    pop_en   = pop & !flush & (count_q != '0);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_en) begin
        mem_d[wr_ptr_q] = push_entry;
        wr_ptr_d        = next_ptr(wr_ptr_q);
      end
      if (pop_en) rd_ptr_d = next_ptr(rd_ptr_q);
      case ({push_en, pop_en})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: validity comes from pointers and occupancy only.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_comb begin
    int off;
    count = count_q;
    head  = mem_q[rd_ptr_q];
    for (int i = 0; i < DEPTH; i++) begin
      off = i - int'(rd_ptr_q);
      if (off < 0) off = off + DEPTH;
      ent_dest[i]  = mem_q[i].dest;
      ent_valid[i] = (off < int'(count_q));
    end
  end

endmodule

// File: rtl/rf_wport_arb.sv
// Single register-file write port shared between the WB stage and buffered
// multi-cycle-unit results, with a starvation bound on the buffered side.
module rf_wport_arb
  import rf_wport_arb_pkg::*;
#(
  parameter  int FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter  int STARVE_MAX = STARVE_MAX_DEF,
  localparam int CW         = $clog2(FIFO_DEPTH + 1),
  localparam int SW         = $clog2(STARVE_MAX + 1)
) (
  input logic           clk,
  input logic           reset,
  rf_wport_arb_if.slave bus
);

  logic [CW-1:0]              count;
  wport_entry_t               head;
  wport_entry_t               push_entry;
  logic [FIFO_DEPTH-1:0][4:0] ent_dest;
  logic [FIFO_DEPTH-1:0]      ent_valid;
  logic                       push, nonempty, fifo_grant;
  logic [SW-1:0]              starve_q, starve_d;

  wport_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .push_entry (push_entry),
    .pop        (fifo_grant),
    .flush      (bus.flush),
    .count      (count),
    .head       (head),
    .ent_dest   (ent_dest),
    .ent_valid  (ent_valid)
  );

  // Ready uses registered occupancy only; a result with dest 0 is accepted
  // and dropped. Reset and flush suppress the FIFO grant so nothing buffered leaks.
  always_comb begin
    nonempty        = (count != '0);
    bus.mdu_ready   = (count < CW'(FIFO_DEPTH)) & !bus.flush;
    push            = bus.mdu_valid & bus.mdu_ready & (bus.mdu_dest != 5'd0);
    push_entry.dest = bus.mdu_dest;
    push_entry.data = bus.mdu_data;
    fifo_grant      = nonempty & !bus.flush & !reset &
                      (!bus.wb_we | (starve_q == SW'(STARVE_MAX)));
    bus.rf_we       = bus.wb_we;
    bus.rf_waddr    = bus.wb_waddr;
    bus.rf_wdata    = bus.wb_wdata;
    bus.wb_stall    = 1'b0;
    if (fifo_grant) begin
      bus.rf_we    = 1'b1;
      bus.rf_waddr = head.dest;
      bus.rf_wdata = head.data;
      bus.wb_stall = bus.wb_we;
    end
  end

  always_comb begin
    starve_d = starve_q;
    if (bus.flush || !nonempty || fifo_grant) starve_d = '0;
    else if (starve_q != SW'(STARVE_MAX))     starve_d = starve_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) starve_q <= '0;
    else       starve_q <= starve_d;
  end

  always_comb begin
    bus.pend_hit1 = 1'b0;
    bus.pend_hit2 = 1'b0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (ent_valid[i] && bus.raddr1 != 5'd0 && ent_dest[i] == bus.raddr1) bus.pend_hit1 = 1'b1;
      if (ent_valid[i] && bus.raddr2 != 5'd0 && ent_dest[i] == bus.raddr2) bus.pend_hit2 = 1'b1;
    end
    bus.dbg_count  = 8'(count);
    bus.dbg_starve = 8'(starve_q);
  end

endmodule

// File: tb/tb_rf_wport_arb.sv
// Directed scoreboard bench for rf_wport_arb: expected rf writes are queued by
// the stimulus and checked by an independent monitor; side outputs are checked inline.
module tb_rf_wport_arb;

  logic clk;
  logic reset;
  int   checks   = 0;
  int   failures = 0;
  logic [36:0] exp_q[$];

  rf_wport_arb_if bus ();

  rf_wport_arb dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- check helper ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle();
    bus.wb_we     = 1'b0;
    bus.wb_waddr  = 5'd0;
    bus.wb_wdata  = 32'd0;
    bus.mdu_valid = 1'b0;
    bus.mdu_dest  = 5'd0;
    bus.mdu_data  = 32'd0;
    bus.flush     = 1'b0;
    bus.raddr1    = 5'd0;
    bus.raddr2    = 5'd0;
  endtask

  task automatic wb(input logic [4:0] a, input logic [31:0] d);
    bus.wb_we    = 1'b1;
    bus.wb_waddr = a;
    bus.wb_wdata = d;
  endtask

  task automatic mdu(input logic [4:0] a, input logic [31:0] d);
    bus.mdu_valid = 1'b1;
    bus.mdu_dest  = a;
    bus.mdu_data  = d;
  endtask

  task automatic mdu_off();
    bus.mdu_valid = 1'b0;
  endtask

  task automatic exp_wr(input logic [4:0] a, input logic [31:0] d);
    exp_q.push_back({a, d});
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [36:0] e;
    if (bus.rf_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("rf_unexpected_write", {27'd0, bus.rf_waddr, bus.rf_wdata}, 64'd0);
      end else begin
        e = exp_q.pop_front();
        chk("rf_write", {27'd0, bus.rf_waddr, bus.rf_wdata}, {27'd0, e});
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1;
    idle();
    cyc();
    cyc();
    reset = 1'b0;
    bus.raddr1 = 5'd5;
    bus.raddr2 = 5'd7;
    @(negedge clk);
    chk("rst_mdu_ready", bus.mdu_ready, 1);
    chk("rst_wb_stall",  bus.wb_stall,  0);
    chk("rst_pend_hit1", bus.pend_hit1, 0);
    chk("rst_pend_hit2", bus.pend_hit2, 0);
    chk("rst_rf_we",     bus.rf_we,     0);
    chk("rst_count",     bus.dbg_count, 0);
    cyc();

    // Single result, WB idle: written the cycle after acceptance.
    idle();
    bus.raddr1 = 5'd5;
    mdu(5'd5, 32'h1234);
    @(negedge clk);
    chk("a_ready",       bus.mdu_ready, 1);
    chk("a_no_bypass",   bus.rf_we,     0);
    chk("a_pend_before", bus.pend_hit1, 0);
    cyc();
    mdu_off();
    exp_wr(5'd5, 32'h1234);
    @(negedge clk);
    chk("a_rf_we",    bus.rf_we,     1);
    chk("a_pend_hit", bus.pend_hit1, 1);
    chk("a_stall",    bus.wb_stall,  0);
    cyc();
    @(negedge clk);
    chk("a_pend_after", bus.pend_hit1, 0);
    chk("a_count",      bus.dbg_count, 0);
    cyc();

    // WB busy: three WB writes, then forced FIFO grant, then stalled WB lands.
    idle();
    bus.raddr2 = 5'd7;
    wb(5'd1, 32'h100);
    mdu(5'd7, 32'hAAAA);
    exp_wr(5'd1, 32'h100);
    @(negedge clk);
    cyc();
    mdu_off();
    for (int i = 2; i <= 4; i++) begin
      wb(5'(i), 32'(i * 256));
      exp_wr(5'(i), 32'(i * 256));
      @(negedge clk);
      chk("b_stall_wb", bus.wb_stall, 0);
      chk("b_pend2",    bus.pend_hit2, 1);
      cyc();
    end
    wb(5'd5, 32'h500);
    exp_wr(5'd7, 32'hAAAA);
    @(negedge clk);
    chk("b_stall_fifo", bus.wb_stall, 1);
    chk("b_pend2_head", bus.pend_hit2, 1);
    cyc();
    exp_wr(5'd5, 32'h500);
    @(negedge clk);
    chk("b_stall_after", bus.wb_stall, 0);
    chk("b_pend2_gone",  bus.pend_hit2, 0);
    cyc();

    // Fill, back-pressure, refused push while popping.
    idle();
    wb(5'd2, 32'h20); mdu(5'd8, 32'h8); exp_wr(5'd2, 32'h20);
    @(negedge clk); chk("c_ready0", bus.mdu_ready, 1); cyc();
    wb(5'd3, 32'h30); mdu(5'd9, 32'h9); exp_wr(5'd3, 32'h30);
    @(negedge clk); chk("c_ready1", bus.mdu_ready, 1); cyc();
    wb(5'd4, 32'h40); mdu(5'd10, 32'hA); exp_wr(5'd4, 32'h40);
    @(negedge clk); chk("c_full_ready", bus.mdu_ready, 0); chk("c_count2", bus.dbg_count, 2); cyc();
    wb(5'd5, 32'h50); exp_wr(5'd5, 32'h50);
    @(negedge clk); chk("c_full_ready2", bus.mdu_ready, 0); cyc();
    wb(5'd6, 32'h60); exp_wr(5'd8, 32'h8);
    @(negedge clk);
    chk("c_pop_stall",   bus.wb_stall,  1);
    chk("c_pop_refused", bus.mdu_ready, 0);
    cyc();
    exp_wr(5'd6, 32'h60);
    @(negedge clk);
    chk("c_count_after_pop", bus.dbg_count, 1);
    chk("c_ready_again",     bus.mdu_ready, 1);
    cyc();
    idle();
    exp_wr(5'd9, 32'h9);
    @(negedge clk); cyc();
    exp_wr(5'd10, 32'hA);
    @(negedge clk); cyc();
    @(negedge clk); chk("c_drained", bus.dbg_count, 0); cyc();

    // Destination 0: handshake but no storage and no write.
    idle();
    mdu(5'd0, 32'hDEAD);
    @(negedge clk); chk("d_ready", bus.mdu_ready, 1); cyc();
    mdu_off();
    @(negedge clk);
    chk("d_no_write", bus.rf_we,     0);
    chk("d_pend0",    bus.pend_hit1, 0);
    chk("d_count",    bus.dbg_count, 0);
    cyc();

    // Flush with a full FIFO: nothing buffered reaches the register file.
    idle();
    bus.raddr1 = 5'd11;
    wb(5'd12, 32'hC1); mdu(5'd11, 32'hB1); exp_wr(5'd12, 32'hC1);
    @(negedge clk); cyc();
    wb(5'd12, 32'hC2); mdu(5'd13, 32'hB2); exp_wr(5'd12, 32'hC2);
    @(negedge clk); cyc();
    mdu_off();
    bus.flush = 1'b1;
    wb(5'd14, 32'hC3); exp_wr(5'd14, 32'hC3);
    @(negedge clk);
    chk("e_flush_ready", bus.mdu_ready, 0);
    chk("e_flush_stall", bus.wb_stall,  0);
    cyc();
    bus.flush = 1'b0;
    bus.wb_we = 1'b0;
    @(negedge clk);
    chk("e_count",  bus.dbg_count,  0);
    chk("e_ready",  bus.mdu_ready,  1);
    chk("e_rf_we",  bus.rf_we,      0);
    chk("e_pend",   bus.pend_hit1,  0);
    chk("e_starve", bus.dbg_starve, 0);
    cyc();
    @(negedge clk); cyc();

    // Reset mid-operation with a full FIFO about to take the port.
    idle();
    wb(5'd1, 32'h11); mdu(5'd15, 32'hF1); exp_wr(5'd1, 32'h11);
    @(negedge clk); cyc();
    wb(5'd2, 32'h12); mdu(5'd16, 32'hF2); exp_wr(5'd2, 32'h12);
    @(negedge clk); cyc();
    mdu_off();
    wb(5'd3, 32'h13); exp_wr(5'd3, 32'h13);
    @(negedge clk); cyc();
    wb(5'd4, 32'h14); exp_wr(5'd4, 32'h14);
    @(negedge clk); chk("f_count2", bus.dbg_count, 2); cyc();
    reset = 1'b1;
    wb(5'd6, 32'h16); exp_wr(5'd6, 32'h16);
    @(negedge clk);
    chk("f_starve_sat", bus.dbg_starve, 3);
    chk("f_rst_stall",  bus.wb_stall,   0);
    cyc();
    reset = 1'b0;
    wb(5'd7, 32'h17); exp_wr(5'd7, 32'h17);
    @(negedge clk);
    chk("f_stall", bus.wb_stall,  0);
    chk("f_ready", bus.mdu_ready, 1);
    chk("f_count", bus.dbg_count, 0);
    cyc();
    idle();
    repeat (3) cyc();

    chk("exp_q_drained", 64'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
